// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: control-flow responder for the program counter.
// Decodes the instruction fetched at pc and answers with branch_en/branch_pc
// or stop_en in the same cycle, so the PC redirects at the next posedge.
// Keeps a return-address stack, a loop counter and a sticky halt/error state.
module pc_branch_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              power,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       instr,
  input  logic              zero_flag,
  output logic              branch_en,
  output logic [ADDR_W-1:0] branch_pc,
  output logic              stop_en,
  output logic              stack_err,
  output logic              illegal_op,
  output logic [SP_W-1:0]   sp
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_JMP  = 4'd1,
    OP_JZ   = 4'd2,
    OP_CALL = 4'd3,
    OP_RET  = 4'd4,
    OP_LDC  = 4'd5,
    OP_DJNZ = 4'd6,
    OP_HALT = 4'd7
  } opcode_e;

  // Registered state
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [7:0]        cnt_q;
  logic              halted_q;
  logic              err_q;

  // Decoded fields and helpers
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] imm_addr;
  logic [ADDR_W-1:0] return_addr;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              stack_full;
  logic              stack_empty;
  logic              active;

  // Update strobes produced by the decoder
  logic push;
  logic pop;
  logic load_cnt;
  logic dec_cnt;
  logic set_halt;
  logic set_err;

  assign opcode      = instr[15:12];
  assign imm_addr    = ADDR_W'(instr[7:0]);
  assign return_addr = pc + ADDR_W'(1);          // wraps 0xFF -> 0x00
  assign push_idx    = IDX_W'(sp_q);
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  // Outputs are also held low during reset, so gate with rst_n here too.
  assign active      = rst_n & power;

  assign stack_err = err_q;
  assign sp        = sp_q;

  // Opcode decode: combinational redirect/stop response plus update strobes.
  always_comb begin
    // NOTE: every output is given a default first so no path leaves it unassigned (no latch).
    branch_en  = 1'b0;
    branch_pc  = '0;
    stop_en    = 1'b0;
    illegal_op = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    set_halt   = 1'b0;
    set_err    = 1'b0;

    if (active) begin
      illegal_op = opcode[3];
      if (halted_q) begin
        stop_en = 1'b1;
      end else begin
        case (opcode)
          OP_JMP: begin
            branch_en = 1'b1;
            branch_pc = imm_addr;
          end
          OP_JZ: begin
            if (zero_flag) begin
              branch_en = 1'b1;
              branch_pc = imm_addr;
            end
          end
          OP_CALL: begin
            if (stack_full) begin
              stop_en  = 1'b1;
              set_halt = 1'b1;
              set_err  = 1'b1;
            end else begin
              branch_en = 1'b1;
              branch_pc = imm_addr;
              push      = 1'b1;
            end
          end
          OP_RET: begin
            if (stack_empty) begin
              stop_en  = 1'b1;
              set_halt = 1'b1;
              set_err  = 1'b1;
            end else begin
              branch_en = 1'b1;
              branch_pc = stack[top_idx];
              pop       = 1'b1;
            end
          end
          OP_LDC: load_cnt = 1'b1;
          OP_DJNZ: begin
            // Counter at zero stays at zero; branch only if the decrement leaves it non-zero.
            if (cnt_q != 8'd0) begin
              dec_cnt = 1'b1;
              if (cnt_q != 8'd1) begin
                branch_en = 1'b1;
                branch_pc = imm_addr;
              end
            end
          end
          OP_HALT: begin
            stop_en  = 1'b1;
            set_halt = 1'b1;
          end
          default: ;  // NOP and undefined opcodes take no action
        endcase
      end
    end
  end

  // Control state: stack pointer, loop counter, sticky halt and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      sp_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (!power) begin
      sp_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        sp_q <= sp_q + SP_W'(1);
      end else if (pop) begin
        sp_q <= sp_q - SP_W'(1);
      end
      if (load_cnt) begin
        cnt_q <= instr[7:0];
      end else if (dec_cnt) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (set_halt) halted_q <= 1'b1;
      if (set_err)  err_q    <= 1'b1;
    end
  end

  // Return-address stack storage; a push writes the slot just above the top.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the stack is small and must read as zero after reset, so it is reset like a register file.
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (push) begin
      stack[push_idx] <= return_addr;
    end
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed testbench for pc_branch_ctrl. Inputs change on the falling edge,
// combinational outputs are sampled 1ns later, state commits on the rising edge.
module tb_pc_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        power;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        zero_flag;
  logic        branch_en;
  logic [7:0]  branch_pc;
  logic        stop_en;
  logic        stack_err;
  logic        illegal_op;
  logic [2:0]  sp;

  int pass_cnt  = 0;
  int check_cnt = 0;

  pc_branch_ctrl #(.ADDR_W(8), .STACK_DEPTH(4), .SP_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .power      (power),
    .pc         (pc),
    .instr      (instr),
    .zero_flag  (zero_flag),
    .branch_en  (branch_en),
    .branch_pc  (branch_pc),
    .stop_en    (stop_en),
    .stack_err  (stack_err),
    .illegal_op (illegal_op),
    .sp         (sp)
  );

  always #5 clk = ~clk;

  // Present one instruction for the coming rising edge and let outputs settle.
  task automatic apply(input logic [7:0] p, input logic [15:0] i, input logic z);
    @(negedge clk);
    pc        = p;
    instr     = i;
    zero_flag = z;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    power = 1'b1;
    apply(8'h05, 16'h3020, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b0 || stop_en !== 1'b0 || sp !== 3'd0)
      $display("FAIL reset_hold: be=%b stop=%b sp=%0d want 0 0 0", branch_en, stop_en, sp);
    else pass_cnt++;

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_cnt++;
    if (branch_en !== 1'b1 || branch_pc !== 8'h20)
      $display("FAIL reset_first_call: be=%b pc=%h want 1 20", branch_en, branch_pc);
    else pass_cnt++;

    @(negedge clk);
    #1;
    check_cnt++;
    if (sp !== 3'd1) $display("FAIL reset_sp_after_call: got %0d want 1", sp);
    else pass_cnt++;

    // Async reset in the middle of a CALL cycle.
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if (sp !== 3'd0 || branch_en !== 1'b0 || branch_pc !== 8'h00 || stop_en !== 1'b0 ||
        stack_err !== 1'b0 || illegal_op !== 1'b0)
      $display("FAIL reset_async: sp=%0d be=%b pc=%h stop=%b err=%b ill=%b want all 0",
               sp, branch_en, branch_pc, stop_en, stack_err, illegal_op);
    else pass_cnt++;

    @(negedge clk);
    rst_n = 1'b1;
    instr = 16'h0000;
    #1;
    check_cnt++;
    if (branch_en !== 1'b0 || stop_en !== 1'b0 || sp !== 3'd0)
      $display("FAIL reset_release: be=%b stop=%b sp=%0d want 0 0 0", branch_en, stop_en, sp);
    else pass_cnt++;
  endtask

  task automatic test_jmp_jz();
    apply(8'h10, 16'h1042, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b1 || branch_pc !== 8'h42)
      $display("FAIL jmp: be=%b pc=%h want 1 42", branch_en, branch_pc);
    else pass_cnt++;

    apply(8'h10, 16'h2050, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b0 || branch_pc !== 8'h00)
      $display("FAIL jz_not_taken: be=%b pc=%h want 0 00", branch_en, branch_pc);
    else pass_cnt++;

    apply(8'h10, 16'h2050, 1'b1);
    check_cnt++;
    if (branch_en !== 1'b1 || branch_pc !== 8'h50)
      $display("FAIL jz_taken: be=%b pc=%h want 1 50", branch_en, branch_pc);
    else pass_cnt++;
  endtask

  task automatic test_call_ret();
    apply(8'h05, 16'h3020, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b1 || branch_pc !== 8'h20)
      $display("FAIL call_outer: be=%b pc=%h want 1 20", branch_en, branch_pc);
    else pass_cnt++;

    apply(8'h21, 16'h3030, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b1 || branch_pc !== 8'h30 || sp !== 3'd1)
      $display("FAIL call_inner: be=%b pc=%h sp=%0d want 1 30 1", branch_en, branch_pc, sp);
    else pass_cnt++;

    apply(8'h31, 16'h4000, 1'b0);
    check_cnt++;
    if (sp !== 3'd2 || branch_en !== 1'b1 || branch_pc !== 8'h22)
      $display("FAIL ret_inner: sp=%0d be=%b pc=%h want 2 1 22", sp, branch_en, branch_pc);
    else pass_cnt++;

    apply(8'h23, 16'h4000, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b1 || branch_pc !== 8'h06)
      $display("FAIL ret_outer: be=%b pc=%h want 1 06", branch_en, branch_pc);
    else pass_cnt++;

    apply(8'h07, 16'h0000, 1'b0);
    check_cnt++;
    if (sp !== 3'd0) $display("FAIL ret_sp_empty: got %0d want 0", sp);
    else pass_cnt++;

    // CALL from the last address pushes a wrapped return address.
    apply(8'hFF, 16'h3010, 1'b0);
    apply(8'h10, 16'h4000, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b1 || branch_pc !== 8'h00 || sp !== 3'd1)
      $display("FAIL call_wrap: be=%b pc=%h sp=%0d want 1 00 1", branch_en, branch_pc, sp);
    else pass_cnt++;
    apply(8'h00, 16'h0000, 1'b0);
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 4; i++) apply(8'(i), 16'h3040, 1'b0);
    apply(8'h04, 16'h3040, 1'b0);
    check_cnt++;
    if (sp !== 3'd4 || stop_en !== 1'b1 || branch_en !== 1'b0)
      $display("FAIL overflow_resp: sp=%0d stop=%b be=%b want 4 1 0", sp, stop_en, branch_en);
    else pass_cnt++;

    for (int i = 0; i < 3; i++) begin
      apply(8'h04, 16'h1042, 1'b0);
      check_cnt++;
      if (stop_en !== 1'b1 || branch_en !== 1'b0 || stack_err !== 1'b1 || sp !== 3'd4)
        $display("FAIL overflow_hold: stop=%b be=%b err=%b sp=%0d want 1 0 1 4",
                 stop_en, branch_en, stack_err, sp);
      else pass_cnt++;
    end

    power = 1'b0;
    apply(8'h00, 16'h0000, 1'b0);
    power = 1'b1;
    apply(8'h00, 16'h0000, 1'b0);
    check_cnt++;
    if (stop_en !== 1'b0 || stack_err !== 1'b0 || sp !== 3'd0)
      $display("FAIL overflow_clear: stop=%b err=%b sp=%0d want 0 0 0", stop_en, stack_err, sp);
    else pass_cnt++;

    apply(8'h00, 16'h4000, 1'b0);
    check_cnt++;
    if (stop_en !== 1'b1 || branch_en !== 1'b0)
      $display("FAIL underflow_resp: stop=%b be=%b want 1 0", stop_en, branch_en);
    else pass_cnt++;

    apply(8'h01, 16'h0000, 1'b0);
    check_cnt++;
    if (stop_en !== 1'b1 || stack_err !== 1'b1 || sp !== 3'd0)
      $display("FAIL underflow_hold: stop=%b err=%b sp=%0d want 1 1 0", stop_en, stack_err, sp);
    else pass_cnt++;

    power = 1'b0;
    apply(8'h00, 16'h0000, 1'b0);
    power = 1'b1;
  endtask

  task automatic test_loop();
    logic exp_be [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    apply(8'h00, 16'h5003, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b0 || stop_en !== 1'b0)
      $display("FAIL ldc: be=%b stop=%b want 0 0", branch_en, stop_en);
    else pass_cnt++;

    for (int i = 0; i < 5; i++) begin
      apply(8'h08, 16'h6008, 1'b0);
      check_cnt++;
      if (branch_en !== exp_be[i] || branch_pc !== (exp_be[i] ? 8'h08 : 8'h00))
        $display("FAIL djnz_%0d: be=%b pc=%h want %b", i, branch_en, branch_pc, exp_be[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_halt_power();
    apply(8'h00, 16'h7000, 1'b0);
    check_cnt++;
    if (stop_en !== 1'b1 || branch_en !== 1'b0)
      $display("FAIL halt: stop=%b be=%b want 1 0", stop_en, branch_en);
    else pass_cnt++;

    apply(8'h01, 16'h1042, 1'b0);
    check_cnt++;
    if (stop_en !== 1'b1 || branch_en !== 1'b0 || stack_err !== 1'b0)
      $display("FAIL halt_sticky: stop=%b be=%b err=%b want 1 0 0", stop_en, branch_en, stack_err);
    else pass_cnt++;

    power = 1'b0;
    apply(8'h01, 16'hA042, 1'b0);
    check_cnt++;
    if (stop_en !== 1'b0 || branch_en !== 1'b0 || illegal_op !== 1'b0)
      $display("FAIL power_off: stop=%b be=%b ill=%b want 0 0 0", stop_en, branch_en, illegal_op);
    else pass_cnt++;

    power = 1'b1;
    apply(8'h01, 16'h0000, 1'b0);
    check_cnt++;
    if (stop_en !== 1'b0) $display("FAIL halt_cleared: stop=%b want 0", stop_en);
    else pass_cnt++;

    apply(8'h01, 16'hA042, 1'b0);
    check_cnt++;
    if (illegal_op !== 1'b1 || branch_en !== 1'b0 || stop_en !== 1'b0)
      $display("FAIL illegal: ill=%b be=%b stop=%b want 1 0 0", illegal_op, branch_en, stop_en);
    else pass_cnt++;

    // Illegal opcode behaves as NOP: the next JMP still works normally.
    apply(8'h02, 16'h1033, 1'b0);
    check_cnt++;
    if (branch_en !== 1'b1 || branch_pc !== 8'h33 || illegal_op !== 1'b0)
      $display("FAIL after_illegal: be=%b pc=%h ill=%b want 1 33 0", branch_en, branch_pc, illegal_op);
    else pass_cnt++;
  endtask

  initial begin
    rst_n     = 1'b0;
    power     = 1'b1;
    pc        = '0;
    instr     = '0;
    zero_flag = 1'b0;
    test_reset();
    test_jmp_jz();
    test_call_ret();
    test_overflow_underflow();
    test_loop();
    test_halt_power();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
